// File: rtl/alu_multicycle.sv
// alu_multicycle: 16-bit multi-cycle ALU for the MIPS-16 datapath.
// Single-cycle ADD/SUB/logic ops; iterative shift-add MUL and restoring DIV.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-low reset
//   start      operation request, sampled only while busy=0
//   alucontrol 3-bit op: ADD SUB MUL DIV AND OR XOR XNOR
//   a, b       operands (dividend/multiplicand, divisor/multiplier)
//   result     result / low product / quotient
//   hi         high product / remainder / 0
//   zero       result==0, updated with done
//   divzero    DIV with b==0, updated with done
//   busy       MUL/DIV iteration in progress
//   done       one-cycle completion pulse
module alu_multicycle #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       alucontrol,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             divzero,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_XNOR = 3'b111;

    logic [1:0]         state_q,   state_d;
    logic [CW-1:0]      cnt_q,     cnt_d;
    logic [2*WIDTH-1:0] work_q,    work_d;
    logic [WIDTH-1:0]   opb_q,     opb_d;
    logic [WIDTH-1:0]   result_q,  result_d;
    logic [WIDTH-1:0]   hi_q,      hi_d;
    logic               zero_q,    zero_d;
    logic               divzero_q, divzero_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;

    // Single-cycle datapath
    logic [WIDTH-1:0] alu_res;

    always_comb begin
        alu_res = '0;
        unique case (alucontrol)
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_XNOR: alu_res = ~(a ^ b);
            default: alu_res = '0;
        endcase
    end

    // MUL step: work = {acc, multiplier}. Add multiplicand into the
    // accumulator when the multiplier LSB is set, then shift the whole
    // register right with the adder carry entering at the top.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    always_comb begin
        mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]}
                 + (work_q[0] ? {1'b0, opb_q} : '0);
        mul_next = {mul_sum, work_q[WIDTH-1:1]};
    end

    // DIV step: work = {remainder, dividend/quotient}. Shift the next
    // dividend bit into the remainder, trial-subtract the divisor and
    // keep the difference only when it did not borrow.
    logic [WIDTH:0]     div_trial;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] div_next;

    always_comb begin
        div_trial = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]}
                  - {1'b0, opb_q};
        div_ge    = ~div_trial[WIDTH];
        div_rem   = div_ge ? div_trial[WIDTH-1:0]
                           : {work_q[2*WIDTH-2:WIDTH], work_q[WIDTH-1]};
        div_next  = {div_rem, work_q[WIDTH-2:0], div_ge};
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        opb_d     = opb_q;
        result_d  = result_q;
        hi_d      = hi_q;
        zero_d    = zero_q;
        divzero_d = divzero_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (alucontrol == OP_MUL) begin
                        state_d = S_MUL;
                        cnt_d   = CW'(WIDTH);
                        work_d  = {{WIDTH{1'b0}}, b};
                        opb_d   = a;
                        busy_d  = 1'b1;
                    end else if (alucontrol == OP_DIV && b != '0) begin
                        state_d = S_DIV;
                        cnt_d   = CW'(WIDTH);
                        work_d  = {{WIDTH{1'b0}}, a};
                        opb_d   = b;
                        busy_d  = 1'b1;
                    end else if (alucontrol == OP_DIV) begin
                        // Divide by zero finishes immediately with
                        // all-ones quotient and the dividend as remainder.
                        result_d  = '1;
                        hi_d      = a;
                        zero_d    = 1'b0;
                        divzero_d = 1'b1;
                        done_d    = 1'b1;
                    end else begin
                        result_d  = alu_res;
                        hi_d      = '0;
                        zero_d    = (alu_res == '0);
                        divzero_d = 1'b0;
                        done_d    = 1'b1;
                    end
                end
            end

            S_MUL: begin
                work_d = mul_next;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d   = S_IDLE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    result_d  = mul_next[WIDTH-1:0];
                    hi_d      = mul_next[2*WIDTH-1:WIDTH];
                    zero_d    = (mul_next[WIDTH-1:0] == '0);
                    divzero_d = 1'b0;
                end
            end

            S_DIV: begin
                work_d = div_next;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d   = S_IDLE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    result_d  = div_next[WIDTH-1:0];
                    hi_d      = div_next[2*WIDTH-1:WIDTH];
                    zero_d    = (div_next[WIDTH-1:0] == '0);
                    divzero_d = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            work_q    <= '0;
            opb_q     <= '0;
            result_q  <= '0;
            hi_q      <= '0;
            zero_q    <= 1'b0;
            divzero_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            opb_q     <= opb_d;
            result_q  <= result_d;
            hi_q      <= hi_d;
            zero_q    <= zero_d;
            divzero_q <= divzero_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign result  = result_q;
    assign hi      = hi_q;
    assign zero    = zero_q;
    assign divzero = divzero_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Multi-cycle 16-bit ALU for the MIPS-16 datapath. It is the consumer of the 3-bit `alucontrol` code produced by the ALU decoder. It executes ADD/SUB/AND/OR/XOR/XNOR in one registered cycle and runs MUL and DIV as iterative shift-add and restoring-divide engines. A start/busy/done handshake lets the controller stall the pipeline while a long operation is in flight.

## Interface
Parameters:
- `WIDTH`, 16, operand/result width; MUL/DIV iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  rising-edge clock; one clock domain only.
- `reset`  in  1  synchronous, active-low reset (sampled on `clk` rising edge; 0 = reset).
- `start`  in  1  operation request; sampled only when `busy`=0.
- `alucontrol`  in  3  operation code: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 AND, 101 OR, 110 XOR, 111 XNOR.
- `a`  in  WIDTH  operand A (dividend / multiplicand).
- `b`  in  WIDTH  operand B (divisor / multiplier).
- `result`  out  WIDTH  result; low product for MUL; quotient for DIV.
- `hi`  out  WIDTH  high product for MUL; remainder for DIV; 0 for all other ops.
- `zero`  out  1  `result`==0, updated with `done`.
- `divzero`  out  1  DIV with `b`==0, updated with `done`.
- `busy`  out  1  high while a MUL/DIV iteration is in progress.
- `done`  out  1  one-cycle pulse; `result`/`hi`/flags are valid from this cycle and hold until the next `done`.

## Operation
- States: IDLE, MUL, DIV. `done` is a registered pulse, not a separate state.
- Reset (`reset`=0 at an edge): state is IDLE; `result`, `hi`, `zero`, `divzero`, `busy`, `done` are all 0; iteration counter and internal registers are cleared.
- IDLE with `start`=1: latch `a`, `b`, `alucontrol`.
  - Codes 000, 001, 100–111: compute combinationally from the latched inputs and register the result at the same edge. `hi`=0 and `divzero`=0. Remain in IDLE.
  - 010: go to MUL with counter = `WIDTH`, accumulator = 0.
  - 011 with `b`≠0: go to DIV with counter = `WIDTH`, remainder = 0.
  - 011 with `b`==0: no iteration. `result`=all ones, `hi`=`a`, `divzero`=1, `done` pulsed as for a single-cycle op.
- MUL: unsigned shift-add, one multiplier bit per cycle, 2·WIDTH-bit product. On the last iteration, register `result`=product[WIDTH-1:0], `hi`=product[2·WIDTH-1:WIDTH], then return to IDLE.
- DIV: unsigned restoring division, one quotient bit per cycle. On the last iteration, register `result`=quotient, `hi`=remainder, then return to IDLE.
- Arithmetic: ADD and SUB wrap modulo 2^WIDTH; no overflow or carry output. Logic ops are bitwise.
- `start` while `busy`=1 is ignored. Operands are not re-sampled and no request is queued.
- `done` cycle: `busy`=0 and `start` is accepted in that same cycle, so back-to-back ops have no bubble.
- Reset mid-MUL/DIV: abort immediately. No `done` is issued and outputs take their reset values.
- Input changes on `a`/`b`/`alucontrol` after acceptance have no effect on the op in flight.

## Timing
- `start` accepted at edge N.
- Single-cycle ops and DIV-by-zero: `done`=1 and results valid in cycle N+1; `busy` stays 0.
- MUL/DIV: `busy`=1 during cycles N+1 … N+WIDTH. In cycle N+WIDTH+1, `done`=1, `busy`=0 and results are valid. With `WIDTH`=16, `done` occurs 17 cycles after acceptance.
- `done` is high for exactly one cycle per accepted op.
- `zero` and `divzero` change only in a `done` cycle or on reset.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- ADD `a`=0x7FFF, `b`=0x0001 → N+1: `result`=0x8000, `hi`=0, `zero`=0, `done`=1 for one cycle, `busy` never high. Then SUB 0x0005−0x0005 → `result`=0x0000, `zero`=1.
- MUL `a`=0x1234, `b`=0x0100 → `busy` high for cycles N+1…N+16. N+17: `result`=0x3400, `hi`=0x0012, `done`=1. Also MUL 0xFFFF×0xFFFF → `result`=0x0001, `hi`=0xFFFE.
- DIV `a`=100, `b`=7 → N+17: `result`=14, `hi`=2, `divzero`=0. Then DIV `a`=0x00AB, `b`=0 → N+1: `result`=0xFFFF, `hi`=0x00AB, `divzero`=1, `busy` never high.
- Start MUL, then pulse `start` with ADD operands at N+3 → ADD ignored; single `done` at N+17 carrying the MUL result. Then issue ADD in that `done` cycle → its `done` arrives at N+18.
- Start DIV, then drive `reset`=0 at N+5 → cycle N+6: all outputs 0, IDLE; no `done` in the following 20 cycles. A new ADD 2+3 afterwards → `result`=5.
- Logic sweep `a`=0xF0F0, `b`=0xFF00 → AND 0xF000, OR 0xFFF0, XOR 0x0FF0, XNOR 0xF00F, each with `done` at N+1.
